// File: rtl/riscky_pkg.sv
// Shared core-wide constants and types for the integer datapath.
package riscky_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DEPTH  = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a register, applies the zero-register
// force and write-to-read bypass, and reports the busy bit for that register.
module regfile_read_port
    import riscky_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int DEPTH    = REG_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  busy_vec,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic is_zero;
    logic bypass_hit;
    logic rsv_hit;

    always_comb begin
        // NOTE: every output gets a default before the conditionals, so no path leaves it unassigned and no latch is inferred.
        is_zero    = ZERO_REG && (rd_addr == '0);
        bypass_hit = BYPASS && wr_en && (wr_addr == rd_addr) && !is_zero;
        rsv_hit    = rsv_en && (rsv_addr == rd_addr);
        rd_data    = regs[rd_addr];
        rd_busy    = busy_vec[rd_addr];

        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (bypass_hit) begin
            rd_data = wr_data;
            // A same-cycle re-reservation keeps the register busy for the consumer.
            if (!rsv_hit) begin
                rd_busy = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_multiport.sv
// Parametrised ID-stage register file with NUM_RD combinational read ports,
// optional hard-wired zero register, write bypass and a RAW busy scoreboard.
module reg_file_multiport
    import riscky_pkg::*;
#(
    parameter int  DATA_W   = XLEN,
    parameter int  DEPTH    = REG_DEPTH,
    localparam int ADDR_W   = $clog2(DEPTH),
    parameter int  NUM_RD   = 2,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_ok;
    logic              rsv_ok;

    always_comb begin
        wr_ok  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
        rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == '0));
        regs_d = regs_q;
        busy_d = busy_q;

        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle reservation wins.
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the storage array is cleared on reset because reads right after reset must return 0, which rules out an unreset RAM.
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .rd_addr (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs_q),
            .busy_vec(busy_q),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rsv_en  (rsv_en),
            .rsv_addr(rsv_addr),
            .rd_data (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed bench for reg_file_multiport: default build (A), no-bypass 3-port build (B)
// and a 16x64 3-port build (C), checked against hand-computed values.
module tb_reg_file_multiport;

    logic clk;
    logic reset;
    logic wr_en, rsv_en;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;

    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic [31:0] busy_vec_a;

    logic [14:0] rd_addr_b;
    logic [95:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic [31:0] busy_vec_b;

    logic         wr_en_c, rsv_en_c;
    logic [3:0]   wr_addr_c, rsv_addr_c;
    logic [63:0]  wr_data_c;
    logic [11:0]  rd_addr_c;
    logic [191:0] rd_data_c;
    logic [2:0]   rd_busy_c;
    logic [15:0]  busy_vec_c;

    int n_pass;
    int n_total;

    reg_file_multiport #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec_a)
    );

    reg_file_multiport #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec_b)
    );

    reg_file_multiport #(.DATA_W(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .rsv_en(rsv_en_c),
        .rsv_addr(rsv_addr_c), .busy_vec(busy_vec_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        rsv_en   = 1'b0;
        wr_en_c  = 1'b0;
        rsv_en_c = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        wr_addr_c = '0; wr_data_c = '0; rsv_addr_c = '0;
        rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = {3{4'd15}};
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        n_total++;
        if (busy_vec_a !== 32'h0) $display("FAIL por_busy_a: got %h want %h", busy_vec_a, 32'h0);
        else n_pass++;
        n_total++;
        if (rd_data_c !== 192'h0) $display("FAIL por_data_c: got %h want 0", rd_data_c);
        else n_pass++;

        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        cycle();
        idle();
        rd_addr_a = {5'd3, 5'd3};
        #1;
        n_total++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF) $display("FAIL reset_prewrite: got %h want %h", rd_data_a[31:0], 32'hDEADBEEF);
        else n_pass++;

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_total++;
        if (rd_data_a !== 64'h0) $display("FAIL reset_data: got %h want 0", rd_data_a);
        else n_pass++;
        n_total++;
        if (rd_busy_a !== 2'b00) $display("FAIL reset_rd_busy: got %b want 00", rd_busy_a);
        else n_pass++;
        n_total++;
        if (busy_vec_a !== 32'h0) $display("FAIL reset_busy_vec: got %h want 0", busy_vec_a);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_addr_a = {5'd0, 5'd0};
        rd_addr_b = {5'd0, 5'd0, 5'd0};
        #1;
        n_total++;
        if (rd_data_a[31:0] !== 32'h0) $display("FAIL zero_same_cycle: got %h want 0", rd_data_a[31:0]);
        else n_pass++;
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (rd_data_a[31:0] !== 32'h0 || rd_data_b !== 96'h0)
                $display("FAIL zero_read[%0d]: got a=%h b=%h want 0", k, rd_data_a[31:0], rd_data_b);
            else n_pass++;
            n_total++;
            if (busy_vec_a[0] !== 1'b0 || busy_vec_b[0] !== 1'b0)
                $display("FAIL zero_busy[%0d]: got a=%b b=%b want 0", k, busy_vec_a[0], busy_vec_b[0]);
            else n_pass++;
            cycle();
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        cycle();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h22;
        rd_addr_a = {5'd5, 5'd0};
        rd_addr_b = {5'd0, 5'd5, 5'd0};
        #1;
        n_total++;
        if (rd_data_a[63:32] !== 32'h22) $display("FAIL bypass_on_data: got %h want %h", rd_data_a[63:32], 32'h22);
        else n_pass++;
        n_total++;
        if (rd_data_b[63:32] !== 32'h11) $display("FAIL bypass_off_data: got %h want %h", rd_data_b[63:32], 32'h11);
        else n_pass++;
        n_total++;
        if (rd_busy_a[1] !== 1'b0) $display("FAIL bypass_on_busy: got %b want 0", rd_busy_a[1]);
        else n_pass++;
        n_total++;
        if (rd_busy_b[1] !== 1'b1) $display("FAIL bypass_off_busy: got %b want 1", rd_busy_b[1]);
        else n_pass++;
        cycle();
        idle();
        #1;
        n_total++;
        if (rd_data_a[63:32] !== 32'h22 || rd_data_b[63:32] !== 32'h22)
            $display("FAIL bypass_next: got a=%h b=%h want 22", rd_data_a[63:32], rd_data_b[63:32]);
        else n_pass++;
        n_total++;
        if (rd_busy_a[1] !== 1'b0 || rd_busy_b[1] !== 1'b0)
            $display("FAIL bypass_next_busy: got a=%b b=%b want 0", rd_busy_a[1], rd_busy_b[1]);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        rd_addr_a = {5'd0, 5'd7};
        rd_addr_b = {5'd0, 5'd0, 5'd7};
        #1;
        n_total++;
        if (rd_busy_a[0] !== 1'b0) $display("FAIL sb_pre_edge: got %b want 0", rd_busy_a[0]);
        else n_pass++;
        cycle();
        idle();
        #1;
        n_total++;
        if (rd_busy_a[0] !== 1'b1) $display("FAIL sb_reserved: got %b want 1", rd_busy_a[0]);
        else n_pass++;
        n_total++;
        if (busy_vec_a !== 32'h80) $display("FAIL sb_vec_set: got %h want %h", busy_vec_a, 32'h80);
        else n_pass++;

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        #1;
        n_total++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1)
            $display("FAIL sb_wb_busy: got a=%b b=%b want a=0 b=1", rd_busy_a[0], rd_busy_b[0]);
        else n_pass++;
        cycle();
        idle();
        #1;
        n_total++;
        if (busy_vec_a !== 32'h0 || rd_data_a[31:0] !== 32'h77)
            $display("FAIL sb_cleared: got vec=%h data=%h want vec=0 data=77", busy_vec_a, rd_data_a[31:0]);
        else n_pass++;

        rsv_en = 1'b1; rsv_addr = 5'd7;
        cycle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        #1;
        n_total++;
        if (rd_busy_a[0] !== 1'b1) $display("FAIL sb_rsv_wb_busy: got %b want 1", rd_busy_a[0]);
        else n_pass++;
        cycle();
        idle();
        #1;
        n_total++;
        if (busy_vec_a !== 32'h80 || rd_data_a[31:0] !== 32'h78)
            $display("FAIL sb_rsv_wins: got vec=%h data=%h want vec=80 data=78", busy_vec_a, rd_data_a[31:0]);
        else n_pass++;

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
        cycle();
        idle();
        #1;
        n_total++;
        if (busy_vec_a !== 32'h0) $display("FAIL sb_final_clear: got %h want 0", busy_vec_a);
        else n_pass++;
    endtask

    task automatic test_multiport();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        wr_en_c = 1'b1; wr_addr_c = 4'd15; wr_data_c = 64'hFEDCBA9876543210;
        rsv_en_c = 1'b1; rsv_addr_c = 4'd15;
        cycle();
        idle();
        rd_addr_b = {5'd9, 5'd9, 5'd9};
        rd_addr_c = {4'd15, 4'd15, 4'd15};
        #1;
        n_total++;
        if (rd_data_b !== {3{32'hA5A5A5A5}}) $display("FAIL mp_same_b: got %h want a5a5a5a5 x3", rd_data_b);
        else n_pass++;
        n_total++;
        if (rd_data_c !== {3{64'hFEDCBA9876543210}}) $display("FAIL mp_same_c: got %h want fedcba9876543210 x3", rd_data_c);
        else n_pass++;
        n_total++;
        if (busy_vec_c !== 16'h8000 || rd_busy_c !== 3'b111)
            $display("FAIL mp_busy_c: got vec=%h busy=%b want vec=8000 busy=111", busy_vec_c, rd_busy_c);
        else n_pass++;

        rd_addr_b = {5'd0, 5'd5, 5'd9};
        #1;
        n_total++;
        if (rd_data_b !== {32'h0, 32'h22, 32'hA5A5A5A5})
            $display("FAIL mp_mixed_b: got %h want 00000000_00000022_a5a5a5a5", rd_data_b);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        rsv_en = 1'b1; rsv_addr = 5'd2;
        cycle();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        cycle();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        cycle();
        idle();
        rd_addr_a = {5'd0, 5'd4};
        #1;
        n_total++;
        if (busy_vec_a !== 32'h54 || rd_data_a[31:0] !== 32'h44)
            $display("FAIL midop_pre: got vec=%h data=%h want vec=54 data=44", busy_vec_a, rd_data_a[31:0]);
        else n_pass++;

        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
        rsv_en = 1'b1; rsv_addr = 5'd8;
        cycle();
        reset = 1'b0;
        idle();
        #1;
        n_total++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0 || busy_vec_c !== 16'h0)
            $display("FAIL midop_busy: got a=%h b=%h c=%h want 0", busy_vec_a, busy_vec_b, busy_vec_c);
        else n_pass++;
        n_total++;
        if (rd_data_a[31:0] !== 32'h0 || rd_busy_a !== 2'b00)
            $display("FAIL midop_reg4: got data=%h busy=%b want 0", rd_data_a[31:0], rd_busy_a);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_multiport();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
